fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and drives the word-aligned fetch address into the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register together with PC+4 and a valid bit.
- Handles stall, flush and branch/jump redirect, and stops fetching on a halt word.

---
 rtl/fetch_stage.sv | 112 +++++++++++
 tb/tb_fetch_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: PC register, IF/ID register, stall/flush/redirect/halt
// Optional FETCH_PERF_CNT_EN adds saturating fetch and stall counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] ImemAddress,
  input  logic [31:0] ImemInstruction,
  output logic [31:0] PC,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        Halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
`endif
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  logic [0:0]  state;
  logic        redirect;
  logic        halt_hit;
  logic        ifid_load;
  logic [31:0] redirect_pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;

  assign redirect    = BranchTaken | Jump;
  assign redirect_pc = BranchTaken ? (BranchTarget & ~32'h3) : (JumpTarget & ~32'h3);
  assign pc_plus4    = PC + 32'd4;
  assign ImemAddress = PC & ~32'h3;
  assign Halted      = (state == ST_HALTED);

  // A halt word only takes effect on an otherwise quiet edge; it is never latched.
  assign halt_hit  = (state == ST_RUN) && (ImemInstruction == HALT_WORD) &&
                     !Stall && !Flush && !redirect;
  assign ifid_load = (state == ST_RUN) && !Stall && !Flush && !redirect && !halt_hit;

  always_comb begin
    pc_next = PC;
    if (redirect) begin
      pc_next = redirect_pc;
    end else if (!Stall && (state == ST_RUN) && !halt_hit) begin
      pc_next = pc_plus4;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      PC    <= RESET_PC;
      state <= ST_RUN;
    end else begin
      PC <= pc_next;
      if (redirect) begin
        state <= ST_RUN;
      end else if (halt_hit) begin
        state <= ST_HALTED;
      end
    end
  end

  // Squash beats hold: a redirect or flush bubbles IF/ID even under stall.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      IFID_Instruction <= NOP_WORD;
      IFID_PCPlus4     <= 32'h0;
      IFID_Valid       <= 1'b0;
    end else if (Flush || redirect) begin
      IFID_Instruction <= NOP_WORD;
      IFID_Valid       <= 1'b0;
    end else if (!Stall) begin
      if (ifid_load) begin
        IFID_Instruction <= ImemInstruction;
        IFID_PCPlus4     <= pc_plus4;
        IFID_Valid       <= 1'b1;
      end else begin
        IFID_Instruction <= NOP_WORD;
        IFID_Valid       <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      FetchCount <= 32'h0;
      StallCount <= 32'h0;
    end else begin
      if (ifid_load && (FetchCount != 32'hFFFF_FFFF)) begin
        FetchCount <= FetchCount + 32'd1;
      end
      if (Stall && !redirect && (StallCount != 32'hFFFF_FFFF)) begin
        StallCount <= StallCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed bench for fetch_stage with reference model and per-cycle compare
module tb_fetch_stage;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic        Jump = 1'b0;
  logic [31:0] JumpTarget = 32'h0;
  logic [31:0] ImemAddress;
  logic [31:0] ImemInstruction;
  logic [31:0] PC;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic        Halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCount;
  logic [31:0] StallCount;
`endif

  logic [31:0] mem [0:255];
  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage dut (
    .Clk(Clk), .Reset_n(Reset_n), .Stall(Stall), .Flush(Flush),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget),
    .ImemAddress(ImemAddress), .ImemInstruction(ImemInstruction),
    .PC(PC), .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4),
    .IFID_Valid(IFID_Valid), .Halted(Halted)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCount(FetchCount), .StallCount(StallCount)
`endif
  );

  always #5 Clk = ~Clk;
  assign ImemInstruction = mem[ImemAddress[9:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: spec priority rules applied to plain variables, memory read by the model itself.
  logic [31:0] m_pc, m_instr, m_pcp4, m_fcnt, m_scnt, m_old_pc, m_word;
  logic        m_valid, m_halted, m_redir, m_halting;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
      m_fcnt = 32'h0; m_scnt = 32'h0;
    end else begin
      m_old_pc  = m_pc;
      m_word    = mem[m_old_pc[9:2]];
      m_redir   = BranchTaken || Jump;
      m_halting = !m_halted && (m_word == 32'hFFFF_FFFF) && !Stall && !Flush && !m_redir;
      if (BranchTaken)                           m_pc = {BranchTarget[31:2], 2'b00};
      else if (Jump)                             m_pc = {JumpTarget[31:2], 2'b00};
      else if (!(Stall || m_halted || m_halting)) m_pc = m_old_pc + 32'd4;
      if (Flush || m_redir) begin
        m_instr = 32'h0; m_valid = 1'b0;
      end else if (!Stall) begin
        if (m_halted || m_halting) begin
          m_instr = 32'h0; m_valid = 1'b0;
        end else begin
          m_instr = m_word; m_pcp4 = m_old_pc + 32'd4; m_valid = 1'b1;
          if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
        end
      end
      if (Stall && !m_redir && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
      if (m_redir) m_halted = 1'b0;
      else if (m_halting) m_halted = 1'b1;
    end
  end

  always @(negedge Clk) begin
    chk("cyc_imem_addr", ImemAddress, {m_pc[31:2], 2'b00});
    chk("cyc_pc", PC, m_pc);
    chk("cyc_ifid_instr", IFID_Instruction, m_instr);
    chk("cyc_ifid_pcp4", IFID_PCPlus4, m_pcp4);
    chk("cyc_ifid_valid", {31'h0, IFID_Valid}, {31'h0, m_valid});
    chk("cyc_halted", {31'h0, Halted}, {31'h0, m_halted});
`ifdef FETCH_PERF_CNT_EN
    chk("cyc_fetch_cnt", FetchCount, m_fcnt);
    chk("cyc_stall_cnt", StallCount, m_scnt);
`endif
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ifid(input string name, input logic [31:0] pc_e, input logic [31:0] ins_e,
                      input logic [31:0] p4_e, input logic v_e);
    chk({name, "_pc"}, PC, pc_e);
    chk({name, "_instr"}, IFID_Instruction, ins_e);
    chk({name, "_pcp4"}, IFID_PCPlus4, p4_e);
    chk({name, "_valid"}, {31'h0, IFID_Valid}, {31'h0, v_e});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i * 3;
    #2;
    ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("reset_halted", {31'h0, Halted}, 32'h0);
    tick();
    Reset_n = 1'b1;
    tick();
    ifid("run1", 32'h4, 32'h0, 32'h4, 1'b1);
    tick();
    ifid("run2", 32'h8, 32'h3, 32'h8, 1'b1);
    Stall = 1'b1;
    tick();
    ifid("stall1", 32'h8, 32'h3, 32'h8, 1'b1);
    tick();
    ifid("stall2", 32'h8, 32'h3, 32'h8, 1'b1);
    Stall = 1'b0;
    tick();
    ifid("unstall", 32'hC, 32'h6, 32'hC, 1'b1);
    BranchTaken = 1'b1; BranchTarget = 32'h42; Jump = 1'b1; JumpTarget = 32'h100;
    tick();
    ifid("br_jmp", 32'h40, 32'h0, 32'hC, 1'b0);
    BranchTaken = 1'b0; Jump = 1'b0;
    tick();
    ifid("after_br", 32'h44, 32'd48, 32'h44, 1'b1);
    BranchTaken = 1'b1; Jump = 1'b1; Stall = 1'b1;
    tick();
    ifid("br_jmp_stall", 32'h40, 32'h0, 32'h44, 1'b0);
    BranchTaken = 1'b0; Stall = 1'b0; JumpTarget = 32'hFFFF_FFFE;
    tick();
    chk("jmp_top_pc", PC, 32'hFFFF_FFFC);
    Jump = 1'b0;
    tick();
    ifid("wrap", 32'h0, 32'd765, 32'h0, 1'b1);
    Flush = 1'b1; Stall = 1'b1;
    tick();
    ifid("flush_stall", 32'h0, 32'h0, 32'h0, 1'b0);
    Flush = 1'b0; Stall = 1'b0;
    mem[4] = 32'hFFFF_FFFF;
    repeat (4) tick();
    ifid("pre_halt", 32'h10, 32'h9, 32'h10, 1'b1);
    tick();
    ifid("halt", 32'h10, 32'h0, 32'h10, 1'b0);
    chk("halt_flag", {31'h0, Halted}, 32'h1);
    tick();
    ifid("halted_hold", 32'h10, 32'h0, 32'h10, 1'b0);
    chk("halted_hold_flag", {31'h0, Halted}, 32'h1);
    Jump = 1'b1; JumpTarget = 32'h0;
    tick();
    chk("unhalt_pc", PC, 32'h0);
    chk("unhalt_flag", {31'h0, Halted}, 32'h0);
    Jump = 1'b0;
    repeat (4) tick();
    Stall = 1'b1;
    tick();
    chk("stall_blocks_halt", {31'h0, Halted}, 32'h0);
    Stall = 1'b0;
    tick();
    chk("halt_after_stall", {31'h0, Halted}, 32'h1);
    Jump = 1'b1; JumpTarget = 32'h20;
    tick();
    Jump = 1'b0; Stall = 1'b1;
    tick();
    Stall = 1'b0;
    tick();
    #2;
    Reset_n = 1'b0;
    #1;
    ifid("async_reset", 32'h0, 32'h0, 32'h0, 1'b0);
    chk("async_reset_halted", {31'h0, Halted}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("async_reset_fcnt", FetchCount, 32'h0);
    chk("async_reset_scnt", StallCount, 32'h0);
`endif
    tick();
    Reset_n = 1'b1;
    repeat (2) tick();
    ifid("post_reset", 32'h8, 32'h3, 32'h8, 1'b1);
    @(negedge Clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
